mem_arbiter: RTL

Two-port access controller in front of the 32×8 single-port data memory. It arbitrates between two requesters (port 0: instruction/fetch side, port 1: data/load-store side) with round-robin fairness. It sequences each access into setup/strobe/hold phases, because the memory's Read/Write inputs are level-sensitive and need the address stable before and after every strobe. It sits between the datapath and the Memory instance; the memory's own `reset` init pulse is driven elsewhere, not by this block.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 14 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the two-port data memory arbiter.
// Holds the access FSM state encoding and the memory geometry.
package mem_arbiter_pkg;

   localparam int MEM_DEPTH  = 32;
   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      ERR
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
// Ports: req[1:0], last (last granted port) -> grant_valid, grant_idx.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   assign grant_valid = |req;
   // Under contention the port that did not win last time goes first.
   assign grant_idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port access controller sequencing setup/strobe/hold for the data memory.
// Ports: clk, reset, req/we/addr/wdata per port -> ack/err/rdata per port,
// busy, and the mem_addr/mem_wdata/mem_write/mem_read/mem_rdata memory side.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state;
   logic              lat_we;
   logic              gnt;
   logic              last;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              grant_valid;
   logic              grant_idx;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_oor;
   logic              done;

   rr_arbiter2 u_rr (
      .req         ({req1, req0}),
      .last        (last),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_we    = grant_idx ? we1    : we0;
   assign sel_addr  = grant_idx ? addr1  : addr0;
   assign sel_wdata = grant_idx ? wdata1 : wdata0;
   assign sel_oor   = 32'(sel_addr) >= $unsigned(DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         gnt       <= 1'b0;
         last      <= 1'b1;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  lat_we    <= sel_we;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
                  gnt       <= grant_idx;
                  last      <= grant_idx;
                  state     <= sel_oor ? ERR : SETUP;
               end
            end
            SETUP:  state <= STROBE;
            STROBE: state <= HOLD;
            HOLD: begin
               // Read data is still held by the memory after the strobe.
               if (!lat_we) begin
                  if (gnt) rdata1 <= mem_rdata;
                  else     rdata0 <= mem_rdata;
               end
               state <= IDLE;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign done      = (state == HOLD) || (state == ERR);
   assign ack0      = done && !gnt;
   assign ack1      = done && gnt;
   assign err0      = (state == ERR) && !gnt;
   assign err1      = (state == ERR) && gnt;
   assign busy      = state != IDLE;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_write = (state == STROBE) && lat_we;
   assign mem_read  = (state == STROBE) && !lat_we;

endmodule
